gpio_led_monitor: RTL and testbench

GPIO_LED_MONITOR -- requirements
Module: gpio_led_monitor

---
 rtl/gpio_led_monitor.sv | 100 ++++++++++
 tb/tb_gpio_led_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_led_monitor.sv
// rtl/gpio_led_monitor.sv - synchronised GPIO to LED monitor: direct, inverted, activity-stretch and toggle modes
// Optional heartbeat divider and output are built only when GPIO_MON_HEARTBEAT_EN is defined.
module gpio_led_monitor #(
  parameter int CHANNELS       = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 12000000,
  parameter int HEARTBEAT_DIV  = 6000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [CHANNELS-1:0]   gpio,
  input  logic [2*CHANNELS-1:0] mode,
`ifdef GPIO_MON_HEARTBEAT_EN
  output logic                  heartbeat,
`endif
  output logic [CHANNELS-1:0]   led
);

  localparam int CW = $clog2(STRETCH_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(STRETCH_CYCLES - 1);

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] p;
  logic [CHANNELS-1:0] t;
  logic [CHANNELS-1:0] t_nxt;
  logic [CHANNELS-1:0] edge_det;
  logic [CHANNELS-1:0] rise_det;
  logic [CHANNELS-1:0] led_nxt;
  logic [CW-1:0]       cnt     [CHANNELS];
  logic [CW-1:0]       cnt_nxt [CHANNELS];

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s ^ p;
  assign rise_det = s & ~p;
  assign t_nxt    = t ^ rise_det;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= gpio;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Counter and toggle state advance in every mode so a mode switch needs no flush.
  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (edge_det[i])
        cnt_nxt[i] = RELOAD;
      else if (cnt[i] != '0)
        cnt_nxt[i] = cnt[i] - CW'(1);
      else
        cnt_nxt[i] = '0;

      case (mode[2*i +: 2])
        2'b00:   led_nxt[i] = s[i];
        2'b10:   led_nxt[i] = ~s[i];
        2'b01:   led_nxt[i] = edge_det[i] | (cnt[i] != '0);
        default: led_nxt[i] = t_nxt[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p   <= '0;
      t   <= '0;
      led <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
    end else begin
      p   <= s;
      t   <= t_nxt;
      led <= led_nxt;
      for (int i = 0; i < CHANNELS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

`ifdef GPIO_MON_HEARTBEAT_EN
  localparam int HW = $clog2(HEARTBEAT_DIV);
  localparam logic [HW-1:0] DIV_LAST = HW'(HEARTBEAT_DIV - 1);

  logic [HW-1:0] div_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q     <= '0;
      heartbeat <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q     <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      div_q     <= div_q + HW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_gpio_led_monitor.sv
// tb/tb_gpio_led_monitor.sv - randomized self-checking bench for gpio_led_monitor against a history-based model
module tb_gpio_led_monitor;

  localparam int CH = 2;
  localparam int SS = 2;
  localparam int ST = 4;
  localparam int HB = 5;

  logic            clk    = 1'b0;
  logic            resetn = 1'b1;
  logic [CH-1:0]   gpio   = '0;
  logic [2*CH-1:0] mode   = '0;
  logic [CH-1:0]   led;
`ifdef GPIO_MON_HEARTBEAT_EN
  logic            heartbeat;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [CH-1:0]   gh [0:8191];
  logic [2*CH-1:0] mh [0:8191];
  int              cyc = 0;
  int              rises [CH];

  always #5 clk = ~clk;

  gpio_led_monitor #(
    .CHANNELS      (CH),
    .SYNC_STAGES   (SS),
    .STRETCH_CYCLES(ST),
    .HEARTBEAT_DIV (HB)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .gpio     (gpio),
    .mode     (mode),
`ifdef GPIO_MON_HEARTBEAT_EN
    .heartbeat(heartbeat),
`endif
    .led      (led)
  );

  // gpio as presented at edge k since reset release; everything before release reads as 0.
  function automatic logic [CH-1:0] g(int k);
    return (k >= 1) ? gh[k] : '0;
  endfunction

  // Synchronised value seen at edge j is g(j-SS), previous sample is g(j-SS-1).
  function automatic logic det(int j, int i);
    logic [CH-1:0] a;
    logic [CH-1:0] b;
    a = g(j - SS);
    b = g(j - SS - 1);
    return (j >= 1) && (a[i] != b[i]);
  endfunction

  function automatic logic [CH-1:0] model_led(int k);
    logic [CH-1:0]   r;
    logic [CH-1:0]   sv;
    logic [2*CH-1:0] m;
    r  = '0;
    sv = g(k - SS);
    m  = mh[k];
    for (int i = 0; i < CH; i++) begin
      case (m[2*i +: 2])
        2'b00: r[i] = sv[i];
        2'b10: r[i] = ~sv[i];
        2'b01: for (int j = k - ST + 1; j <= k; j++) if (det(j, i)) r[i] = 1'b1;
        default: r[i] = (rises[i] % 2) == 1;
      endcase
    end
    return r;
  endfunction

  task automatic tick(input string tag);
    int k;
    logic [CH-1:0] exp_led;
    logic [CH-1:0] sv;
    cyc++;
    k = cyc;
    gh[k] = gpio;
    mh[k] = mode;
    @(posedge clk);
    #1;
    sv = g(k - SS);
    for (int i = 0; i < CH; i++) if (det(k, i) && sv[i]) rises[i]++;
    exp_led = model_led(k);
    vectors++;
    assert (led === exp_led) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d mode=%b led=%b expected %b", tag, k, mode, led, exp_led);
    end
`ifdef GPIO_MON_HEARTBEAT_EN
    vectors++;
    assert (heartbeat === (((k / HB) % 2) == 1)) else begin
      miscompares++;
      $error("FAIL %s_hb cyc=%0d heartbeat=%b expected %b", tag, k, heartbeat, ((k / HB) % 2) == 1);
    end
`endif
  endtask

  task automatic check_reset_zero(input string tag);
    vectors++;
    assert (led === '0) else begin
      miscompares++;
      $error("FAIL %s led=%b expected %b", tag, led, {CH{1'b0}});
    end
`ifdef GPIO_MON_HEARTBEAT_EN
    vectors++;
    assert (heartbeat === 1'b0) else begin
      miscompares++;
      $error("FAIL %s_hb heartbeat=%b expected 0", tag, heartbeat);
    end
`endif
  endtask

  // Asserts reset mid-cycle (asynchronously), holds it, releases one step after an edge.
  task automatic do_reset(input int hold);
    #2 resetn = 1'b0;
    #1 check_reset_zero("reset_async");
    repeat (hold) begin
      @(posedge clk);
      #1 check_reset_zero("reset_hold");
    end
    resetn = 1'b1;
    cyc = 0;
    for (int i = 0; i < CH; i++) rises[i] = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    mode = 4'b0000;
    gpio = 2'b00;
    do_reset(3);

    // Direct: gpio[0] rises at cycle 10.
    repeat (9) tick("direct");
    gpio = 2'b01;
    repeat (10) tick("direct");
    gpio = 2'b00;
    repeat (6) tick("direct");

    // Activity retrigger: two one-cycle pulses two cycles apart.
    mode = 4'b0101;
    repeat (8) tick("act_idle");
    gpio = 2'b01; tick("act_retrig");
    gpio = 2'b00; tick("act_retrig");
    gpio = 2'b01; tick("act_retrig");
    gpio = 2'b00;
    repeat (12) tick("act_retrig");
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 5) == 0) gpio = gpio ^ CH'($urandom_range(1, 3));
      tick("act_rand");
    end

    // Toggle on channel 1: three rising edges with random hold times.
    mode = 4'b1111;
    gpio = 2'b00;
    repeat (6) tick("tog_idle");
    for (int n = 0; n < 3; n++) begin
      gpio[1] = 1'b1;
      repeat ($urandom_range(1, 5)) tick("tog_rise");
      gpio[1] = 1'b0;
      repeat ($urandom_range(1, 5)) tick("tog_fall");
    end
    repeat (4) tick("tog_tail");

    // Random modes and inputs, both channels changing independently.
    for (int n = 0; n < 600; n++) begin
      if (n % 16 == 0) mode = 4'($urandom);
      if ($urandom_range(0, 3) == 0) gpio = CH'($urandom);
      tick("mixed");
    end

    // Reset mid-stretch, then static gpio=0 must give no pulse.
    mode = 4'b0101;
    gpio = 2'b00;
    repeat (8) tick("mid_pre");
    gpio = 2'b11;
    repeat (SS + 1 + 2) tick("mid_stretch");
    gpio = 2'b00;
    do_reset(2);
    repeat (12) tick("mid_post");

    // Inverted after reset, with heartbeat running when built in.
    mode = 4'b1010;
    gpio = 2'b00;
    do_reset(2);
    repeat (24) tick("inverted");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
